// File: rtl/ofdm_time_sync_stream.sv
// Streaming OFDM timing synchroniser.
// Tracks a running cyclic-prefix autocorrelation P and window energy E per
// accepted sample. It finds the sync-symbol boundary by a peak search over one
// CP-length window, then emits the CP-stripped bodies of NUM_SYM data symbols.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   restart         synchronous abort back to search (beats in_valid)
//   in_valid/data   input sample stream (gaps allowed)
//   out_valid/data  CP-stripped samples, 2 cycles after the accepting edge
//   out_sos/sof/eof symbol / frame framing flags (0 when out_valid=0)
//   sym_idx         symbol number of the current output sample
//   sync_locked     high from the peak decision to the end of the frame
module ofdm_time_sync_stream #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FFT_N      = 64,
    parameter int unsigned CP_LEN     = 16,
    parameter int unsigned NUM_SYM    = 8,
    parameter int unsigned THRESH     = 12,
    parameter int unsigned MIN_ENERGY = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       restart,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_data,
    output logic                       out_valid,
    output logic signed [DATA_W-1:0]   out_data,
    output logic                       out_sos,
    output logic                       out_sof,
    output logic                       out_eof,
    output logic [$clog2(NUM_SYM)-1:0] sym_idx,
    output logic                       sync_locked
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(CP_LEN) + 1;
    localparam int unsigned CMP_W  = ACC_W + 6;
    localparam int unsigned ADDR_W = $clog2(FFT_N);
    localparam int unsigned CPA_W  = $clog2(CP_LEN);
    localparam int unsigned CNT_W  = $clog2(FFT_N + CP_LEN);
    localparam int unsigned SYM_W  = $clog2(NUM_SYM);
    localparam int unsigned WARM   = FFT_N + CP_LEN - 1;

    typedef enum logic [1:0] {S_SEARCH, S_PEAK, S_SKIP, S_OUT} state_t;

    // Delay lines: raw samples (FFT_N deep) and per-sample terms (CP_LEN deep)
    logic signed [DATA_W-1:0] x_ram [FFT_N];
    logic signed [PROD_W-1:0] c_ram [CP_LEN];
    logic        [PROD_W-1:0] e_ram [CP_LEN];

    logic        [ADDR_W-1:0] wptr;
    logic        [CNT_W-1:0]  warm_cnt;
    logic signed [ACC_W-1:0]  p_acc;
    logic        [ACC_W-1:0]  e_acc;
    logic                     v1, w1;
    logic signed [DATA_W-1:0] d1;
    logic                     v2, det2;
    logic signed [DATA_W-1:0] d2;
    logic signed [ACC_W-1:0]  p2;

    state_t                   state;
    logic signed [ACC_W-1:0]  peak;
    logic        [CPA_W:0]    off;
    logic        [CPA_W-1:0]  pk_cnt;
    logic        [CPA_W:0]    skip_left;
    logic        [CNT_W-1:0]  cnt;
    logic        [SYM_W-1:0]  sym;

    logic        [CPA_W-1:0]  cp_idx_c;
    logic signed [DATA_W-1:0] x_old_c;
    logic signed [PROD_W-1:0] c_new_c, c_old_c, sq_c;
    logic        [PROD_W-1:0] e_new_c, e_old_c;
    logic signed [ACC_W-1:0]  p_next_c;
    logic        [ACC_W-1:0]  e_next_c;
    logic signed [CMP_W-1:0]  lhs_c, rhs_c;
    logic                     det_c, upd_c;
    logic        [CPA_W:0]    off_n_c;

    // Running-sum update; history reads are forced to 0 until they have been written since (re)start
    always_comb begin
        cp_idx_c = wptr[CPA_W-1:0];
        x_old_c  = (warm_cnt >= CNT_W'(FFT_N)) ? x_ram[wptr] : '0;
        c_old_c  = (warm_cnt >= CNT_W'(CP_LEN)) ? c_ram[cp_idx_c] : '0;
        e_old_c  = (warm_cnt >= CNT_W'(CP_LEN)) ? e_ram[cp_idx_c] : '0;
        c_new_c  = in_data * x_old_c;
        sq_c     = in_data * in_data;
        e_new_c  = $unsigned(sq_c);
        p_next_c = p_acc + ACC_W'(c_new_c) - ACC_W'(c_old_c);
        e_next_c = e_acc + ACC_W'(e_new_c) - ACC_W'(e_old_c);
    end

    // Ratio test 16*P >= THRESH*E done with shifts and a constant multiply
    always_comb begin
        lhs_c = CMP_W'(p_acc) <<< 4;
        rhs_c = $signed(CMP_W'(e_acc)) * $signed(CMP_W'(THRESH));
        det_c = w1 && !p_acc[ACC_W-1] && (p_acc != '0) && (lhs_c >= rhs_c)
                && (e_acc >= ACC_W'(MIN_ENERGY));
    end

    // Peak tracking: strict compare keeps the earliest index on ties
    always_comb begin
        upd_c   = (p2 > peak);
        off_n_c = upd_c ? '0 : off + (CPA_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (in_valid && !restart) begin
            x_ram[wptr]     <= in_data;
            c_ram[cp_idx_c] <= c_new_c;
            e_ram[cp_idx_c] <= e_new_c;
        end
    end

    // Stage 1: accept sample, update P/E
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_acc <= '0; e_acc <= '0; wptr <= '0; warm_cnt <= '0;
            v1 <= 1'b0; w1 <= 1'b0; d1 <= '0;
        end else if (restart) begin
            p_acc <= '0; e_acc <= '0; wptr <= '0; warm_cnt <= '0;
            v1 <= 1'b0; w1 <= 1'b0;
        end else if (in_valid) begin
            p_acc    <= p_next_c;
            e_acc    <= e_next_c;
            wptr     <= wptr + ADDR_W'(1);
            warm_cnt <= (warm_cnt == CNT_W'(WARM)) ? warm_cnt : warm_cnt + CNT_W'(1);
            w1       <= (warm_cnt == CNT_W'(WARM));
            v1       <= 1'b1;
            d1       <= in_data;
        end else begin
            v1 <= 1'b0;
        end
    end

    // Stage 2: register detect decision alongside the sample and its P
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0; det2 <= 1'b0; d2 <= '0; p2 <= '0;
        end else if (restart) begin
            v2 <= 1'b0; det2 <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                d2   <= d1;
                p2   <= p_acc;
                det2 <= det_c;
            end
        end
    end

    // Stage 3: frame FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_SEARCH; peak <= '0; off <= '0; pk_cnt <= '0;
            skip_left <= '0; cnt <= '0; sym <= '0;
            out_valid <= 1'b0; out_data <= '0; out_sos <= 1'b0; out_sof <= 1'b0;
            out_eof <= 1'b0; sym_idx <= '0; sync_locked <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sos   <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            if (restart) begin
                state       <= S_SEARCH;
                sync_locked <= 1'b0;
            end else if (v2) begin
                case (state)
                    S_SEARCH: begin
                        if (det2) begin
                            state  <= S_PEAK;
                            peak   <= p2;
                            off    <= '0;
                            pk_cnt <= CPA_W'(1);
                        end
                    end
                    S_PEAK: begin
                        if (upd_c) peak <= p2;
                        off <= off_n_c;
                        if (pk_cnt == CPA_W'(CP_LEN - 1)) begin
                            sync_locked <= 1'b1;
                            state       <= S_SKIP;
                            // samples still to drop through n_p+CP_LEN
                            skip_left   <= (CPA_W+1)'(CP_LEN) - off_n_c;
                        end else begin
                            pk_cnt <= pk_cnt + CPA_W'(1);
                        end
                    end
                    S_SKIP: begin
                        if (skip_left <= (CPA_W+1)'(1)) begin
                            state <= S_OUT;
                            cnt   <= '0;
                            sym   <= '0;
                        end else begin
                            skip_left <= skip_left - (CPA_W+1)'(1);
                        end
                    end
                    S_OUT: begin
                        if (cnt < CNT_W'(FFT_N)) begin
                            out_valid <= 1'b1;
                            out_data  <= d2;
                            sym_idx   <= sym;
                            out_sos   <= (cnt == '0);
                            out_sof   <= (cnt == '0) && (sym == '0);
                            if ((cnt == CNT_W'(FFT_N - 1)) && (sym == SYM_W'(NUM_SYM - 1))) begin
                                out_eof     <= 1'b1;
                                sync_locked <= 1'b0;
                                state       <= S_SEARCH;
                            end
                        end
                        if (cnt == CNT_W'(FFT_N + CP_LEN - 1)) begin
                            cnt <= '0;
                            sym <= sym + SYM_W'(1);
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= S_SEARCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ofdm_time_sync_stream.sv
// Scoreboard bench for ofdm_time_sync_stream: driver pushes expected outputs
// as samples are accepted, a monitor pops and compares on every out_valid.
module tb_ofdm_time_sync_stream;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              restart = 1'b0;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_data = '0;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              out_sos, out_sof, out_eof;
    logic [2:0]        sym_idx;
    logic              sync_locked;

    ofdm_time_sync_stream #(
        .DATA_W(8), .FFT_N(64), .CP_LEN(16), .NUM_SYM(8), .THRESH(12), .MIN_ENERGY(256)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_sos(out_sos), .out_sof(out_sof),
        .out_eof(out_eof), .sym_idx(sym_idx), .sync_locked(sync_locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [7:0] d;
        bit emit, sos, sof, eof;
        int sym;
        int acc;
    } exp_t;

    exp_t info[$];
    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Monitor
    always begin
        @(posedge clk);
        #1;
        if (!rst && mon_en) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", out_data, mon_e.d);
                    chk("flags_sos_sof_eof", {out_sos, out_sof, out_eof},
                        {mon_e.sos, mon_e.sof, mon_e.eof});
                    chk("sym_idx", sym_idx, mon_e.sym);
                    chk("latency", cyc - mon_e.acc, 2);
                    chk("sync_locked_in_frame", sync_locked, !mon_e.eof);
                end
            end else begin
                chk("idle_flags", {out_sos, out_sof, out_eof}, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic void push_s(input int v, input bit emit, input bit sos,
                                   input bit sof, input bit eof, input int sym);
        exp_t e;
        e.d = 8'(v); e.emit = emit; e.sos = sos; e.sof = sof; e.eof = eof;
        e.sym = sym; e.acc = 0;
        info.push_back(e);
    endfunction

    function automatic void add_zeros(input int n);
        for (int i = 0; i < n; i++) push_s(0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void add_noise(input int n);
        for (int i = 0; i < n; i++) push_s(int'($urandom_range(0, 6)) - 3, 0, 0, 0, 0, 0);
    endfunction

    // Sync symbol (+-40, CP copied from body tail) then 8 data symbols of
    // magnitude 1..20 whose sign flips every 64 samples so they never correlate.
    function automatic void add_frame(input bit tie);
        int body[64];
        int v, p, k;
        for (int i = 0; i < 64; i++) body[i] = ($urandom_range(0, 1) == 1) ? 40 : -40;
        for (int i = 0; i < 16; i++) push_s(body[48 + i], 0, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) push_s(body[i], 0, 0, 0, 0, 0);
        for (int j = 0; j < 640; j++) begin
            p = j % 80;
            k = j / 80;
            v = int'($urandom_range(1, 20));
            if ((j / 64) % 2 == 1) v = -v;
            if (tie && j == 0) v = body[0];  // P one sample after the true peak equals it
            push_s(v, p >= 16, p == 16, (p == 16) && (k == 0), (k == 7) && (p == 79), k);
        end
    endfunction

    task automatic run_stream(input bit gapped, input int stop_at, input int restart_at);
        exp_t e;
        for (int i = 0; i < info.size(); i++) begin
            if (i == stop_at) break;
            if (gapped) begin
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++) begin
                    in_valid = 1'b0;
                    tick();
                end
            end
            if (i == restart_at) begin
                restart  = 1'b1;
                in_valid = 1'b1;
                in_data  = info[i].d;
                sb.delete();
                tick();
                restart  = 1'b0;
                in_valid = 1'b0;
                chk("restart_out_valid", out_valid, 0);
                chk("restart_sync_locked", sync_locked, 0);
                return;
            end
            in_valid = 1'b1;
            in_data  = info[i].d;
            if (info[i].emit) begin
                e = info[i];
                e.acc = cyc + 1;
                sb.push_back(e);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("reset_outputs", {out_valid, out_data, out_sos, out_sof, out_eof, sym_idx, sync_locked}, 0);
        tick();
        rst = 1'b0;
        mon_en = 1'b1;

        // Idle after reset
        repeat (100) tick();
        chk("idle_outputs", {out_valid, out_data, out_sos, out_sof, out_eof, sym_idx, sync_locked}, 0);

        // Silence then low-level noise: energy stays below MIN_ENERGY
        info.delete(); add_zeros(500); add_noise(500);
        run_stream(0, -1, -1);
        drain();
        chk("noise_sync_locked", sync_locked, 0);

        // Nominal frame then back-to-back frame with a P tie, continuous input
        info.delete(); add_zeros(100); add_frame(0); add_frame(1); add_zeros(100);
        run_stream(0, -1, -1);
        drain();
        chk("after_frames_sync_locked", sync_locked, 0);

        // Gapped input
        info.delete(); add_zeros(100); add_frame(0); add_zeros(100);
        run_stream(1, -1, -1);
        drain();

        // restart while the 30th output sample is on the bus
        info.delete(); add_zeros(100); add_frame(0);
        run_stream(0, -1, 228);
        repeat (5) tick();
        chk("post_restart_idle", {out_valid, sync_locked}, 0);

        // Following frame locks normally after warm-up
        info.delete(); add_zeros(100); add_frame(0); add_zeros(100);
        run_stream(0, -1, -1);
        drain();

        // Asynchronous reset in the middle of output
        info.delete(); add_zeros(100); add_frame(0);
        run_stream(0, 260, -1);
        chk("pre_reset_out_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {out_valid, out_data, out_sos, out_sof, out_eof, sym_idx, sync_locked}, 0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (100) tick();
        chk("idle_after_reset", {out_valid, out_data, out_sos, out_sof, out_eof, sym_idx, sync_locked}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
